// File: rtl/tone_pkg.sv
// tone_pkg: shared tone timing defaults, demodulator state encoding and bin codes.
package tone_pkg;
   localparam int HP0_DEF = 37796;
   localparam int HP1_DEF = 42424;
   localparam int HP2_DEF = 47620;
   localparam int HP3_DEF = 50451;
   localparam int CNT_W = 17;
   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
   typedef logic [2:0] bin_t;
   localparam bin_t BIN_NONE = 3'd4;
   function automatic logic [3:0] one_hot(input bin_t b);
      return (b == BIN_NONE) ? 4'd0 : 4'b0001 << b[1:0];
   endfunction
endpackage

// File: rtl/tone_period_meter.sv
// tone_period_meter: synchronizes rx_in, flags every transition and measures the cycles between them.
module tone_period_meter
   import tone_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_in,
   output logic             edge_pulse,
   output logic [CNT_W-1:0] meas,
   output logic [CNT_W-1:0] count
);
   logic [2:0] sync;
   logic [CNT_W-1:0] inc;
   logic toggle;
   always_comb begin
      toggle = sync[1] ^ sync[2];
      inc = &count ? count : count + 1'b1;
   end
   // meas includes the detection cycle, so edges P cycles apart measure exactly P
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
         edge_pulse <= 1'b0;
         meas <= '0;
         count <= '0;
      end else begin
         sync <= {sync[1:0], rx_in};
         edge_pulse <= toggle;
         meas <= toggle ? inc : meas;
         count <= toggle ? '0 : inc;
      end
   end
endmodule

// File: rtl/tone_demodulator.sv
// tone_demodulator: classifies measured half-periods into tones and locks onto a stable tone.
module tone_demodulator
   import tone_pkg::*;
#(
   parameter int HP0 = HP0_DEF,
   parameter int HP1 = HP1_DEF,
   parameter int HP2 = HP2_DEF,
   parameter int HP3 = HP3_DEF,
   parameter int TOL = 1024,
   parameter int LOCK_CNT = 4,
   parameter int MISS_MAX = 2,
   parameter int TIMEOUT = 60000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       locked
);
   localparam logic [7:0] LOCK_C = 8'(LOCK_CNT);
   localparam logic [7:0] MISS_C = 8'(MISS_MAX);
   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
   logic edge_pulse;
   logic [CNT_W-1:0] meas, count;
   state_t state, state_n;
   bin_t bin, cand, cand_n;
   logic [7:0] match_cnt, match_n, miss_cnt, miss_n;
   logic [3:0] data_q, data_n;
   logic valid_q, valid_n;
   tone_period_meter u_meter (
      .clk(clk),
      .rst(rst),
      .rx_in(rx_in),
      .edge_pulse(edge_pulse),
      .meas(meas),
      .count(count)
   );
   function automatic logic near(input logic [CNT_W-1:0] m, input int hp);
      int d;
      d = int'(m) - hp;
      return (d <= TOL) && (d >= -TOL);
   endfunction
   always_comb bin = near(meas, HP0) ? 3'd0 : near(meas, HP1) ? 3'd1 :
                     near(meas, HP2) ? 3'd2 : near(meas, HP3) ? 3'd3 : BIN_NONE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cand <= BIN_NONE;
         match_cnt <= '0;
         miss_cnt <= '0;
         data_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state <= state_n;
         cand <= cand_n;
         match_cnt <= match_n;
         miss_cnt <= miss_n;
         data_q <= data_n;
         valid_q <= valid_n;
      end
   end
   // an edge always wins over a coincident timeout
   always_comb begin
      state_n = state;
      cand_n = cand;
      match_n = match_cnt;
      miss_n = miss_cnt;
      data_n = data_q;
      valid_n = 1'b0;
      if (edge_pulse) begin
         if (state == IDLE) begin
            state_n = ACQUIRE;
            cand_n = BIN_NONE;
            match_n = '0;
            miss_n = '0;
         end else if (state == ACQUIRE) begin
            cand_n = bin;
            match_n = (bin == cand && bin != BIN_NONE) ? match_cnt + 1'b1 : {7'd0, bin != BIN_NONE};
            if (match_n == LOCK_C) begin
               state_n = LOCKED;
               miss_n = '0;
               data_n = one_hot(bin);
               valid_n = 1'b1;
            end
         end else begin
            miss_n = (bin == cand) ? '0 : miss_cnt + 1'b1;
            if (miss_n == MISS_C) begin
               state_n = ACQUIRE;
               cand_n = bin;
               match_n = {7'd0, bin != BIN_NONE};
               miss_n = '0;
               data_n = '0;
               valid_n = 1'b1;
            end
         end
      end else if (state != IDLE && count >= TMO) begin
         state_n = IDLE;
         data_n = '0;
         valid_n = |data_q;
      end
   end
   always_comb begin
      data_out = {4'd0, data_q};
      valid = valid_q;
      locked = state == LOCKED;
   end
endmodule

// File: doc/tone_demodulator.md
TONE_DEMODULATOR -- requirements
Module: tone_demodulator

Interface
REQ-001 Parameter HP0, default 37796: nominal half-period of tone 0, in clk cycles.
REQ-002 Parameters HP1/HP2/HP3, defaults 42424/47620/50451: nominal half-periods of tones 1-3, in clk cycles.
REQ-003 Parameter TOL, default 1024: acceptance window in cycles; a measurement matches tone i when |meas - HPi| <= TOL.
REQ-004 Parameter LOCK_CNT, default 4: consecutive matching measurements required to lock.
REQ-005 Parameter MISS_MAX, default 2: consecutive non-matching measurements required to drop lock.
REQ-006 Parameter TIMEOUT, default 60000: cycles without an edge before the block returns to IDLE; must exceed max(HPi)+TOL.
REQ-007 Port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-008 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 Port rx_in, input, 1 bit: asynchronous tone stream (square wave from the modulated link).
REQ-010 Port data_out, output, 8 bits: one-hot decoded tone in bits 3:0; bits 7:4 are always 0.
REQ-011 Port valid, output, 1 bit: one-cycle pulse whenever data_out changes value.
REQ-012 Port locked, output, 1 bit: high while in state LOCKED.

Function
REQ-013 rx_in SHALL pass through a 2-flop synchronizer; any transition (rise or fall) of the synchronized signal SHALL produce a one-cycle edge pulse.
REQ-014 A 17-bit period counter SHALL increment every cycle, saturate at 131071, and on an edge pulse capture its value as meas and restart at 0.
REQ-015 Classification SHALL yield bin in {0,1,2,3,NONE}; bins are non-overlapping for the default parameters; no match gives NONE.
REQ-016 States: IDLE, ACQUIRE, LOCKED; IDLE is entered at reset.
REQ-017 IDLE: the first edge SHALL move to ACQUIRE with candidate = NONE and match_cnt = 0; that first meas SHALL be discarded.
REQ-018 ACQUIRE, on edge, when bin == candidate and bin != NONE: match_cnt SHALL increment.
REQ-019 ACQUIRE, on edge, otherwise: candidate = bin and match_cnt = (bin != NONE ? 1 : 0).
REQ-020 When match_cnt reaches LOCK_CNT, the block SHALL enter LOCKED, set data_out = one-hot(candidate), and pulse valid.
REQ-021 LOCKED, on edge, when bin == locked tone: miss_cnt SHALL be cleared.
REQ-022 LOCKED, on edge, otherwise: miss_cnt SHALL increment; when it reaches MISS_MAX, the block SHALL enter ACQUIRE with candidate = bin, match_cnt = (bin != NONE ? 1 : 0), data_out = 0, and pulse valid.
REQ-023 In any state except IDLE, the counter reaching TIMEOUT SHALL force IDLE and data_out = 0; valid SHALL pulse only if data_out was nonzero.
REQ-024 Latency: data_out/valid/locked SHALL update on the cycle after the edge pulse, i.e. 4 clk after an rx_in transition.
REQ-025 An edge in the same cycle the counter would reach TIMEOUT SHALL be processed as an edge; the timeout is not taken.
REQ-026 valid SHALL never assert on two consecutive cycles.

Reset
REQ-027 rst SHALL clear synchronizer flops, period counter, match_cnt and miss_cnt; state SHALL be IDLE; data_out = 0x00, valid = 0, locked = 0.
REQ-028 rst asserted mid-lock SHALL take effect on the next clk edge with no valid pulse; rst SHALL have priority over every other event.

Structure
REQ-029 Tone half-period defaults, state encoding and the bin NONE code SHALL live in shared package tone_pkg, which the modulator side also uses.
REQ-030 Sub-module tone_period_meter SHALL hold the synchronizer, edge detect and period counter, outputting the edge pulse and meas; the FSM and classifier sit in the top level.

Verification
REQ-031 Scenario: square wave, half-period 42424, 6 transitions -> locked = 1, data_out = 0x02, single valid pulse 4 clk after the 5th transition.
REQ-032 Scenario: lock on tone 0, then hold rx_in constant -> data_out = 0x00, locked = 0 and one valid pulse when the counter hits 60000.
REQ-033 Scenario: half-period 45000 for 20 transitions -> locked stays 0, data_out stays 0x00, no valid pulse.
REQ-034 Scenario: lock on tone 0, switch to half-period 50451 -> 0x01 holds through the 1st mismatch, 0x00 after the 2nd, 0x08 after the 5th tone-3 half-period.
REQ-035 Scenario: half-period 38820 (HP0+TOL) locks to 0x01; half-period 38821 never locks.
REQ-036 Scenario: rst pulsed while locked on tone 2 -> next cycle data_out = 0x00, locked = 0, valid = 0; relock needs 5 transitions.
